// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan capture block and the display drivers.
package seven_seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [3:0] ANODE_D0    = 4'b1110;
    localparam logic [3:0] ANODE_D1    = 4'b1101;
    localparam logic [3:0] ANODE_D2    = 4'b1011;
    localparam logic [3:0] ANODE_D3    = 4'b0111;
    localparam logic [3:0] ANODE_BLANK = 4'b1111;

    // Active-low glyphs {dp,g,f,e,d,c,b,a} with the decimal point off.
    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;
    localparam logic [7:0] GLYPH_A = 8'h88;
    localparam logic [7:0] GLYPH_B = 8'h83;
    localparam logic [7:0] GLYPH_C = 8'hC6;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_F = 8'h8E;

    typedef enum logic {
        WAIT = 1'b0,
        HELD = 1'b1
    } filter_state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] idx;
    } anode_dec_t;

    function automatic anode_dec_t decode_anode(input logic [3:0] code);
        anode_dec_t d;
        case (code)
            ANODE_D0: d = '{legal: 1'b1, idx: 2'd0};
            ANODE_D1: d = '{legal: 1'b1, idx: 2'd1};
            ANODE_D2: d = '{legal: 1'b1, idx: 2'd2};
            ANODE_D3: d = '{legal: 1'b1, idx: 2'd3};
            default:  d = '{legal: 1'b0, idx: 2'd0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seven_seg_glyph_decode.sv
// Combinational 7-segment glyph to hex nibble decoder.
// Present only when SEVEN_SEG_HEX_DECODE_EN is defined.
`ifdef SEVEN_SEG_HEX_DECODE_EN
module seven_seg_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       ok,
    output logic [3:0] nibble
);

    logic [6:0] gfedcba_s;

    assign gfedcba_s = {seg[SEG_G], seg[SEG_F], seg[SEG_E], seg[SEG_D],
                        seg[SEG_C], seg[SEG_B], seg[SEG_A]};

    // Match against the shared glyph set; anything else is unrecognised.
    always_comb begin
        ok     = 1'b1;
        nibble = 4'h0;
        case (gfedcba_s)
            GLYPH_0[6:0]: nibble = 4'h0;
            GLYPH_1[6:0]: nibble = 4'h1;
            GLYPH_2[6:0]: nibble = 4'h2;
            GLYPH_3[6:0]: nibble = 4'h3;
            GLYPH_4[6:0]: nibble = 4'h4;
            GLYPH_5[6:0]: nibble = 4'h5;
            GLYPH_6[6:0]: nibble = 4'h6;
            GLYPH_7[6:0]: nibble = 4'h7;
            GLYPH_8[6:0]: nibble = 4'h8;
            GLYPH_9[6:0]: nibble = 4'h9;
            GLYPH_A[6:0]: nibble = 4'hA;
            GLYPH_B[6:0]: nibble = 4'hB;
            GLYPH_C[6:0]: nibble = 4'hC;
            GLYPH_D[6:0]: nibble = 4'hD;
            GLYPH_E[6:0]: nibble = 4'hE;
            GLYPH_F[6:0]: nibble = 4'hF;
            default: begin
                ok     = 1'b0;
                nibble = 4'h0;
            end
        endcase
    end

endmodule
`endif

// File: rtl/seven_seg_scan_capture.sv
// Rebuilds four digit patterns from a multiplexed seven-segment scan.
// SEVEN_SEG_HEX_DECODE_EN adds the hex_val/hex_ok glyph decode outputs.
module seven_seg_scan_capture
    import seven_seg_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  anode_in,
    output logic [31:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        anode_err,
    output logic        stale
`ifdef SEVEN_SEG_HEX_DECODE_EN
    ,
    output logic [15:0] hex_val,
    output logic [3:0]  hex_ok
`endif
);

    localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    STABLE_MAX   = 8'(STABLE_CYCLES);

    logic [11:0]   sync_r [SYNC_STAGES];
    logic [11:0]   pair_s;
    logic [11:0]   prev_r;
    logic [3:0]    a_s;
    logic [7:0]    s_s;
    filter_state_t state_r;
    logic [7:0]    stab_cnt_r;
    logic [TW-1:0] tcnt_r;
    logic [3:0]    seen_r;
    logic [3:0]    seen_next_s;
    anode_dec_t    dec_s;
    logic          same_s;
    logic          accept_s;
    logic          legal_acc_s;
    logic          err_acc_s;
    logic          timeout_hit_s;

    // Synchroniser chain; idles high like the undriven active-low pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 12'hFFF;
        end else begin
            sync_r[0] <= {anode_in, seg_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
    end

    assign pair_s = sync_r[SYNC_STAGES-1];
    assign a_s    = pair_s[11:8];
    assign s_s    = pair_s[7:0];

    // Accept decision and its classification by anode code.
    always_comb begin
        dec_s       = decode_anode(a_s);
        same_s      = (pair_s == prev_r);
        seen_next_s = seen_r | ~a_s;
        if ((state_r == WAIT) && same_s && ((stab_cnt_r + 8'd1) == STABLE_MAX)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        legal_acc_s   = accept_s && dec_s.legal;
        err_acc_s     = accept_s && !dec_s.legal && (a_s != ANODE_BLANK);
        timeout_hit_s = !legal_acc_s && (tcnt_r == TIMEOUT_LAST);
    end

    // Stability filter: one accept per run of identical samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= WAIT;
            stab_cnt_r <= 8'd0;
            prev_r     <= 12'hFFF;
        end else begin
            prev_r <= pair_s;
            case (state_r)
                WAIT: begin
                    if (!same_s) begin
                        stab_cnt_r <= 8'd1;
                    end else begin
                        stab_cnt_r <= stab_cnt_r + 8'd1;
                        if (accept_s) state_r <= HELD;
                    end
                end
                HELD: begin
                    if (!same_s) begin
                        state_r    <= WAIT;
                        stab_cnt_r <= 8'd1;
                    end
                end
                default: begin
                    state_r    <= WAIT;
                    stab_cnt_r <= 8'd0;
                end
            endcase
        end
    end

    // Digit capture, frame tracking and the stale watchdog; a legal accept beats expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= 32'hFFFF_FFFF;
            digit_valid <= 4'h0;
            frame_done  <= 1'b0;
            anode_err   <= 1'b0;
            stale       <= 1'b0;
            seen_r      <= 4'h0;
            tcnt_r      <= '0;
        end else begin
            frame_done <= 1'b0;
            anode_err  <= err_acc_s;
            if (legal_acc_s) begin
                digits[{dec_s.idx, 3'b000} +: 8] <= s_s;
                digit_valid[dec_s.idx]           <= 1'b1;
                tcnt_r                           <= '0;
                stale                            <= 1'b0;
                if (seen_next_s == 4'hF) begin
                    frame_done <= 1'b1;
                    seen_r     <= 4'h0;
                end else begin
                    seen_r <= seen_next_s;
                end
            end else if (timeout_hit_s) begin
                tcnt_r      <= TIMEOUT_MAX;
                stale       <= 1'b1;
                digit_valid <= 4'h0;
                seen_r      <= 4'h0;
            end else if (tcnt_r != TIMEOUT_MAX) begin
                tcnt_r <= tcnt_r + TW'(1);
            end
        end
    end

`ifdef SEVEN_SEG_HEX_DECODE_EN
    logic       hex_hit_s;
    logic [3:0] hex_nib_s;

    seven_seg_glyph_decode u_glyph_decode (
        .seg    (s_s[6:0]),
        .ok     (hex_hit_s),
        .nibble (hex_nib_s)
    );

    // Decoded value is captured on the same edge as the raw pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_val <= 16'h0000;
            hex_ok  <= 4'h0;
        end else if (legal_acc_s) begin
            hex_val[{dec_s.idx, 2'b00} +: 4] <= hex_nib_s;
            hex_ok[dec_s.idx]                <= hex_hit_s;
        end else if (timeout_hit_s) begin
            hex_ok <= 4'h0;
        end
    end
`endif

endmodule

// File: doc/seven_seg_scan_capture.md
# seven_seg_scan_capture

Receive side of the four-digit multiplexed seven-segment scan interface. The block samples the time-multiplexed segment and anode lines, synchronises and filters them, and rebuilds the four per-digit segment patterns into stable registers. It is used as an on-chip display monitor and as the bench-side checker for scan drivers. It also reports scan errors, completed frames and a stalled scan.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser depth on seg_in/anode_in; legal range 2..4
- STABLE_CYCLES, 4, number of consecutive identical synchronised samples required to accept a dwell; legal range 2..255
- TIMEOUT_CYCLES, 65536, idle cycles without an accept before `stale` asserts; must be ≥ 2

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- seg_in  in  8  segment lines, active-low, bit order {dp,g,f,e,d,c,b,a}
- anode_in  in  4  digit enables, active-low one-hot; bit i selects digit i
- digits  out  32  captured patterns, digit i on [8i+7:8i]
- digit_valid  out  4  digit i captured since reset or since the last timeout
- frame_done  out  1  one-cycle pulse when all four digits have been accepted since the previous frame
- anode_err  out  1  one-cycle pulse when an accepted dwell has an illegal anode code
- stale  out  1  level; no accept for TIMEOUT_CYCLES cycles

## Operation
- Inputs pass through a SYNC_STAGES flop chain. All further logic uses the synchronised pair {a_s, s_s}.
- Stability filter FSM:
  - WAIT: the counter increments while the current pair equals the previous pair. Any change reloads the counter to 1.
  - When the counter reaches STABLE_CYCLES, perform the accept and move to HELD.
  - HELD: no further accepts. Any change in the pair returns the FSM to WAIT with the counter at 1.
- Accept action, by anode code:
  - Legal one-hot-low anode (1110, 1101, 1011, 0111): write s_s to digits[i], set digit_valid[i] and seen[i], reload the timeout counter.
  - Anode 1111 (blanking): silently ignored. No write, no error, and the timeout counter is not reloaded.
  - Any other code: pulse anode_err. No write.
- Frame: seen[3:0] is internal.
  - When an accept sets the last missing seen bit, frame_done pulses on the same edge and seen clears to 0000.
  - A digit accepted repeatedly before the frame completes overwrites its register but does not pulse frame_done.
- Timeout:
  - The counter increments each cycle and saturates.
  - On reaching TIMEOUT_CYCLES: stale=1, digit_valid=0000, seen=0000. The digits registers hold their values.
  - The next legal accept clears stale.
- Reset values: digits=32'hFFFF_FFFF (all segments off), digit_valid=0, frame_done=0, anode_err=0, stale=0, seen=0, FSM=WAIT, all counters 0, synchroniser flops 1 (idle high).

## Timing
- Latency from a pin change to the digits update is SYNC_STAGES+STABLE_CYCLES clk cycles, provided the pins stay constant throughout.
- digits, digit_valid, frame_done and anode_err all update on the same edge as the accept.
- A dwell shorter than STABLE_CYCLES synchronised samples is never accepted, so glitches are discarded.
- A legal accept and timeout expiry on the same edge: the accept wins. The timeout counter reloads, stale stays or becomes 0, and digit_valid[i] is set.
- Assertion of rst_n mid-dwell: outputs return to reset values immediately. Capture restarts with a full SYNC_STAGES+STABLE_CYCLES delay after release.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- SEVEN_SEG_HEX_DECODE_EN defined:
  - Adds outputs hex_val (16 bits, nibble i for digit i) and hex_ok (4 bits).
  - On each legal accept, s_s is decoded, ignoring dp, against the standard active-low 0–F glyph set. Result and ok flag are registered on the accept edge.
  - An unrecognised pattern gives nibble 0 and hex_ok[i]=0.
  - Timeout clears hex_ok. Reset values: hex_val=0, hex_ok=0.
- Macro undefined: these ports and the decode logic are absent. All other behaviour is identical.

## Structure
- Package seven_seg_pkg holds:
  - segment bit-index constants (SEG_A..SEG_DP)
  - the four legal anode codes and ANODE_BLANK=4'b1111
  - the 16 active-low glyph constants GLYPH_0..GLYPH_F, shared with the display drivers
  - the filter FSM state enum (WAIT, HELD)
- One sub-module, seven_seg_glyph_decode, is combinational. It maps 7 segments to {ok, nibble} and is instantiated only under SEVEN_SEG_HEX_DECODE_EN.

## Test plan
- **Clean scan.** Drive the patterns C0, F9, A4, B0 on anodes 1110, 1101, 1011, 0111, with 20-cycle dwells. Required: digits=32'hB0A4F9C0, digit_valid=1111, and a frame_done pulse exactly once per 80-cycle rotation. With the macro: hex_val=16'h3210 and hex_ok=1111.
- **Glitch rejection.** Insert a 2-cycle pulse of anode 1101 with seg 00 inside a digit-0 dwell, using STABLE_CYCLES=4. Required: digits[15:8] unchanged and no frame_done.
- **Illegal anode.** Hold anode 1100 for 10 cycles. Required: a single anode_err pulse, no digit change, and digit_valid unchanged.
- **Timeout.** Use TIMEOUT_CYCLES=100 and hold anode at 1111. Required: stale=1 and digit_valid=0000 at cycle 100, with digits held. A following legal dwell on digit 2 gives stale=0 and digit_valid=0100.
- **Latency and reset.** Step digit 3 to 8'h80. Required: digits[31:24]=80 exactly SYNC_STAGES+STABLE_CYCLES=6 cycles after the step. Then assert rst_n mid-dwell: all outputs return to their reset values asynchronously.
